// File: rtl/tt_um_serial_subtractor8_pkg.sv
// Shared types and uio bit map for the byte-serial subtractor.
// SUB_SIGNED_OVF_EN (optional) enables the signed-overflow flag on uio_out[2].
package sub_serial_pkg;

  typedef enum logic {
    EXP_A = 1'b0,
    EXP_B = 1'b1
  } state_e;

  // uio_in bit positions
  localparam int VALID  = 0;
  localparam int FIRST  = 1;
  localparam int SEL    = 2;
  // uio_out bit positions
  localparam int ERR    = 3;
  localparam int OVALID = 4;
  localparam int BORROW = 5;
  localparam int ZERO   = 6;
  localparam int LAST   = 7;
  localparam int OVF    = 2;

  localparam int NUM_BYTES_DEF = 4;

  localparam logic [7:0] UIO_OE_BASE = 8'b1111_1000;

  typedef struct packed {
    logic last;
    logic zero;
    logic borrow;
    logic ovalid;
    logic err;
  } stat_t;

endpackage

// File: rtl/tt_um_serial_subtractor8_borrow_sub8.sv
// Combinational a - b - bin as a Kogge-Stone adder on a + ~b + ~bin.
// bout is the inverted carry out of the top bit.
module borrow_sub8 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  localparam int LEVELS = $clog2(W);

  logic         cin;
  logic [W-1:0] g0, p0, g_all, p_all;
  logic [W:0]   c;

  assign cin = ~bin;
  assign g0  = a & ~b;
  assign p0  = a ^ ~b;

  genvar k;
  generate
    for (k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int D = 1 << k;
      logic [W-1:0] g_in, p_in, g_out, p_out;
      if (k == 0) begin : g_src
        assign g_in = g0;
        assign p_in = p0;
      end else begin : g_chain
        assign g_in = g_lvl[k-1].g_out;
        assign p_in = g_lvl[k-1].p_out;
      end
      // Low D positions already span down to bit 0, so propagate passes through.
      assign g_out = g_in | (p_in & (g_in << D));
      assign p_out = p_in & ((p_in << D) | W'((1 << D) - 1));
    end
  endgenerate

  assign g_all = g_lvl[LEVELS-1].g_out;
  assign p_all = g_lvl[LEVELS-1].p_out;

  assign c    = {g_all | (p_all & {W{cin}}), cin};
  assign d    = p0 ^ c[W-1:0];
  assign bout = ~c[W];

endmodule

// File: rtl/tt_um_serial_subtractor8.sv
// Byte-serial multi-byte subtractor: A/B byte pairs LSB-first, one difference byte out per pair.
// Optional SUB_SIGNED_OVF_EN adds a word-level signed overflow flag on uio_out[2].
module tt_um_serial_subtractor8
  import sub_serial_pkg::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  localparam int IDX_W = (NUM_BYTES > 2) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);

  state_e          state;
  logic [IDX_W-1:0] byte_idx;
  logic            borrow_r;
  logic            zero_acc;
  logic [7:0]      a_hold;
  logic [7:0]      diff_q;
  stat_t           st;

  logic       in_valid, first, sel;
  logic [7:0] diff;
  logic       bout, word_end, diff_zero;
  logic       unused_ok;

  assign in_valid  = uio_in[VALID];
  assign first     = uio_in[FIRST];
  assign sel       = uio_in[SEL];
  assign unused_ok = &{1'b0, uio_in[7:3]};

  borrow_sub8 #(.W(8)) u_sub (
    .a    (a_hold),
    .b    (ui_in),
    .bin  (borrow_r),
    .d    (diff),
    .bout (bout)
  );

  assign word_end  = (byte_idx == IDX_LAST);
  assign diff_zero = (diff == 8'h00);

`ifdef SUB_SIGNED_OVF_EN
  logic ovf_q, ovf_next;
  // Sign bits of the top byte decide overflow for the whole word.
  assign ovf_next = word_end & (a_hold[7] ^ ui_in[7]) & (a_hold[7] ^ diff[7]);
  assign uio_oe   = UIO_OE_BASE | (8'b1 << OVF);
`else
  assign uio_oe   = UIO_OE_BASE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EXP_A;
      byte_idx <= '0;
      borrow_r <= 1'b0;
      zero_acc <= 1'b1;
      a_hold   <= '0;
      diff_q   <= '0;
      st       <= '0;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      st.ovalid <= 1'b0;
      st.last   <= 1'b0;
      st.err    <= 1'b0;
      if (ena && in_valid) begin
        if (!sel) begin
          a_hold <= ui_in;
          state  <= EXP_B;
          if (first) begin
            byte_idx <= '0;
            borrow_r <= 1'b0;
            zero_acc <= 1'b1;
          end
        end else if (state == EXP_B) begin
          st.err    <= first;
          diff_q    <= diff;
          st.borrow <= bout;
          st.ovalid <= 1'b1;
          st.last   <= word_end;
          st.zero   <= word_end & zero_acc & diff_zero;
          state     <= EXP_A;
`ifdef SUB_SIGNED_OVF_EN
          ovf_q     <= ovf_next;
`endif
          if (word_end) begin
            byte_idx <= '0;
            borrow_r <= 1'b0;
            zero_acc <= 1'b1;
          end else begin
            byte_idx <= byte_idx + 1'b1;
            borrow_r <= bout;
            zero_acc <= zero_acc & diff_zero;
          end
        end else begin
          st.err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    uio_out         = '0;
    uio_out[ERR]    = st.err;
    uio_out[OVALID] = st.ovalid;
    uio_out[BORROW] = st.borrow;
    uio_out[ZERO]   = st.zero;
    uio_out[LAST]   = st.last;
`ifdef SUB_SIGNED_OVF_EN
    uio_out[OVF]    = ovf_q;
`endif
  end

  assign uo_out = diff_q;

endmodule

// File: tb/tb_tt_um_serial_subtractor8.sv
// Self-checking bench for tt_um_serial_subtractor8 against a word-level arithmetic model.
module tb_tt_um_serial_subtractor8;

  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uio_out, uio_oe, uo_out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] held_d;
  logic       held_b;

  tt_um_serial_subtractor8 #(.NUM_BYTES(NB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic sel, input logic first, input logic [7:0] b);
    ui_in  = b;
    uio_in = {5'b0, sel, first, 1'b1};
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    uio_in = 8'h00;
    @(posedge clk);
    #1;
  endtask

  // Expected result of byte i of the word subtraction wa - wb.
  task automatic pair(input logic [31:0] wa, input logic [31:0] wb, input int i,
                      input logic fa, input logic fb);
    longint unsigned mask;
    longint          r;
    logic [31:0]     dw;
    logic [7:0]      e_d;
    logic            e_bor, e_last, e_zero, e_ovf;
    mask   = (64'd1 << (8 * (i + 1))) - 1;
    dw     = wa - wb;
    e_d    = dw[8*i +: 8];
    e_bor  = (longint'(wa) & mask) < (longint'(wb) & mask);
    e_last = (i == NB - 1);
    e_zero = e_last && (wa == wb);
    r      = longint'($signed(wa)) - longint'($signed(wb));
    e_ovf  = e_last && (r > 64'sd2147483647 || r < -64'sd2147483648);

    send(1'b0, fa, wa[8*i +: 8]);
    chk("a_ovalid", uio_out[4], 1'b0);
    chk("a_err", uio_out[3], 1'b0);
    send(1'b1, fb, wb[8*i +: 8]);
    chk("diff", uo_out, e_d);
    chk("ovalid", uio_out[4], 1'b1);
    chk("borrow", uio_out[5], e_bor);
    chk("zero", uio_out[6], e_zero);
    chk("last", uio_out[7], e_last);
    chk("err", uio_out[3], fb);
`ifdef SUB_SIGNED_OVF_EN
    chk("ovf", uio_out[2], e_ovf);
`else
    chk("ovf_tied", uio_out[2], 1'b0);
`endif
    held_d = e_d;
    held_b = e_bor;
  endtask

  task automatic word(input logic [31:0] wa, input logic [31:0] wb, input logic f);
    for (int i = 0; i < NB; i++) pair(wa, wb, i, f && (i == 0), 1'b0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
`ifdef SUB_SIGNED_OVF_EN
    chk("uio_oe", uio_oe, 8'b1111_1100);
`else
    chk("uio_oe", uio_oe, 8'b1111_1000);
`endif
    rst_n = 1'b1;
    idle();

    // directed words
    word(32'h0000_0100, 32'h0000_0001, 1'b1);
    word(32'h0000_0000, 32'h0000_0001, 1'b1);
    word(32'h1234_5678, 32'h1234_5678, 1'b1);

    // B byte while expecting A: err pulse only, state untouched
    send(1'b1, 1'b0, 8'h05);
    chk("stray_err", uio_out[3], 1'b1);
    chk("stray_ovalid", uio_out[4], 1'b0);
    chk("stray_hold_d", uo_out, held_d);
    chk("stray_hold_b", uio_out[5], held_b);
    idle();
    chk("err_pulse", uio_out[3], 1'b0);
    word(32'hA5A5_0001, 32'h0000_0002, 1'b0);

    // abort a partial word with first
    pair(32'h0000_0000, 32'hFFFF_FFFF, 0, 1'b1, 1'b0);
    pair(32'h0000_0000, 32'hFFFF_FFFF, 1, 1'b0, 1'b0);
    word(32'h0000_0002, 32'h0000_0001, 1'b1);

    // A overwrite in EXP_B, and first on a B byte
    send(1'b0, 1'b1, 8'h55);
    pair(32'h0301_0210, 32'h0102_0311, 0, 1'b0, 1'b0);
    pair(32'h0301_0210, 32'h0102_0311, 1, 1'b0, 1'b1);
    pair(32'h0301_0210, 32'h0102_0311, 2, 1'b0, 1'b0);
    pair(32'h0301_0210, 32'h0102_0311, 3, 1'b0, 1'b0);

    // ena low: drop bytes and clear pulses
    pair(32'h1122_3344, 32'h0102_0345, 0, 1'b1, 1'b0);
    ena = 1'b0;
    send(1'b0, 1'b0, 8'hEE);
    chk("ena_ovalid", uio_out[4], 1'b0);
    send(1'b1, 1'b0, 8'h01);
    chk("ena_drop_ovalid", uio_out[4], 1'b0);
    chk("ena_drop_err", uio_out[3], 1'b0);
    chk("ena_hold_d", uo_out, held_d);
    ena = 1'b1;
    for (int i = 1; i < NB; i++) pair(32'h1122_3344, 32'h0102_0345, i, 1'b0, 1'b0);

    // async reset mid-word
    pair(32'h0000_0000, 32'h0000_0101, 0, 1'b1, 1'b0);
    pair(32'h0000_0000, 32'h0000_0101, 1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_uo", uo_out, 8'h00);
    chk("arst_uio", uio_out, 8'h00);
    uio_in = 8'h00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    word(32'h0000_0300, 32'h0000_0100, 1'b0);

    // signed overflow words
    word(32'h8000_0000, 32'h0000_0001, 1'b1);
    word(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    // random words
    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rb = (k % 5 == 0) ? ra : $urandom;
      word(ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_um_serial_subtractor8.md
Name: tt_um_serial_subtractor8

Overview:
- Byte-serial multi-byte subtractor for the TinyTapeout tile; the inverse-operation companion to the team's 8-bit Kogge-Stone adder.
- Accepts minuend and subtrahend bytes LSB-first over the shared 8-bit input bus.
- Propagates a borrow flop across bytes and emits one registered difference byte per operand pair, with word-level borrow and zero flags.

Parameters:
- NUM_BYTES, 4, bytes per word (2..16); sets when `last` fires and the borrow/word state clears.

Ports:
- clk  input  1  tile clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- ena  input  1  design enable; low = hold all state, ignore inputs
- ui_in  input  8  operand byte (minuend or subtrahend per uio_in[2])
- uio_in  input  8  [0] in_valid, [1] first (start of word), [2] sel (0=minuend A, 1=subtrahend B); [7:3] ignored
- uio_out  output  8  [3] err, [4] out_valid, [5] borrow, [6] zero, [7] last; [2:0] tied 0
- uio_oe  output  8  constant 8'b1111_1000
- uo_out  output  8  registered difference byte

Behaviour:
- Reset: all output registers 0, state EXP_A, byte_idx=0, borrow_r=0, zero_acc=1, a_hold=0.
- FSM states:
  - EXP_A: waiting for a minuend byte.
  - EXP_B: minuend held, waiting for a subtrahend byte.
- Handshake: every clk with ena=1 and in_valid=1 is one byte transfer. There is no backpressure, so the block must accept one byte per cycle.
- A byte (sel=0), from either state:
  - a_hold <= ui_in; go to EXP_B.
  - In EXP_B this overwrites the held A without error.
- first=1 on an A byte: byte_idx<=0, borrow_r<=0, zero_acc<=1 before use. This aborts any partial word and produces no output for it.
- B byte (sel=1) in EXP_B:
  - diff9 = {1'b0,a_hold} - {1'b0,ui_in} - borrow_r, 9-bit.
  - Next edge: uo_out<=diff9[7:0], borrow out<=diff9[8], out_valid<=1, return to EXP_A.
  - Latency: one clk from the B byte to out_valid.
- B byte in EXP_A:
  - Ignored: no state change, no out_valid.
  - err pulses high for 1 cycle.
- first=1 with sel=1: first is ignored; the byte is handled as a normal B byte. Also pulse err.
- Per computed byte:
  - borrow_r<=diff9[8].
  - zero_acc<=zero_acc & (diff9[7:0]==0).
  - byte_idx increments.
- Word end (byte_idx==NUM_BYTES-1 when computed):
  - last=1 with that out_valid.
  - zero = zero_acc & (diff==0), i.e. zero for the whole word.
  - borrow = final borrow, i.e. unsigned A<B.
  - Then byte_idx wraps to 0, borrow_r<=0, zero_acc<=1.
- Non-final bytes: zero and last are 0.
- Pulse rules:
  - out_valid, last and err are single-cycle pulses.
  - uo_out and borrow hold their values until the next out_valid.
- ena=0: all registers hold and pulse outputs deassert. in_valid bytes are dropped.
- Asynchronous reset mid-word: immediate return to reset values; the partial word is lost.

Optional Feature:
- SUB_SIGNED_OVF_EN
  - Defined: uio_out[2] becomes an output and uio_oe=8'b1111_1100. On the last byte it carries signed overflow (A[msb]^B[msb]) & (A[msb]^D[msb]) for the full word; otherwise 0.
  - Undefined: uio_out[2]=0 and uio_oe=8'b1111_1000. No overflow logic is generated.

Decomposition:
- Package sub_serial_pkg:
  - State enum {EXP_A, EXP_B}.
  - uio bit-index constants: VALID=0, FIRST=1, SEL=2, ERR=3, OVALID=4, BORROW=5, ZERO=6, LAST=7, OVF=2.
  - Default NUM_BYTES.
  - UIO_OE_BASE constant.
- Sub-module borrow_sub8: combinational 8-bit a - b - bin giving {bout, d[7:0]}. It is built as a parallel-prefix (Kogge-Stone) generate/propagate network on a + ~b + ~bin, with bout = ~carry_out.
- The top instantiates one borrow_sub8 plus the FSM and registers.

Test Plan:
All words are 4 bytes and sent LSB-first as A/B byte pairs.
1. 0x00000100 - 0x00000001 → outputs FF (borrow 1), 00, 00, 00. The last byte has last=1, borrow=0, zero=0.
2. 0x00000000 - 0x00000001 → FF, FF, FF, FF. The final byte has borrow=1, last=1.
3. 0x12345678 - 0x12345678 → four 00 outputs. The final byte has zero=1, borrow=0, and ovf=0 when the macro is defined.
4. B byte 0x05 sent in EXP_A → err pulse next cycle, no out_valid, state and byte_idx unchanged.
5. Two pairs of word X, then A byte with first=1 and a fresh word 0x00000002 - 0x00000001 → 01, 00, 00, 00. last fires on the 4th byte of the new word; no output for the aborted word.
6. rst_n low for one cycle after byte 2 of a word → all outputs 0 immediately. A following full word computes correctly from byte_idx=0 with borrow=0.
7. With SUB_SIGNED_OVF_EN defined: 0x80000000 - 0x00000001 → last byte ovf=1. 0x7FFFFFFF - 0xFFFFFFFF → ovf=1.
